mul32_seq_ctrl: RTL

//  Sequencing controller that computes a 32x32 -> 64-bit unsigned product by time-multiplexing
//  one instance of the team's 16x16 unsigned multiplier (Multiplier_16X16) over four cycles.
//  It sits in the FPU mantissa path, feeding the normaliser/rounder, and uses a valid/ready

---
 rtl/mul32_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl: 32x32 -> 64-bit unsigned multiply built from one 16x16
// multiplier used over four consecutive cycles, with valid/ready on both sides.
// MUL_LAT register stages (0..2) sit between the 16x16 product and the accumulator.
// Optional build macro MUL_SEQ_EARLY_ZERO_EN: a zero operand skips the multiplier
// and goes straight to DONE with prod=0.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready=1
// S_MUL  | issuing partial products 0..3, then draining the MUL_LAT pipeline
// S_DONE | prod valid, held until out_ready
module mul32_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] prod,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  // The last partial product is issued at count 3 and reaches the accumulator
  // MUL_LAT cycles later.
  localparam logic [2:0] LAST_CNT = 3'(3 + MUL_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;

  logic        issue;
  logic [1:0]  issue_step;
  logic [15:0] mul_x, mul_y;
  logic [31:0] mul_p;
  logic        em_v;
  logic [1:0]  em_step;
  logic [31:0] em_pp;
  logic [63:0] addend;

  // Operand select for the shared 16x16 multiplier: bit 0 of the step picks aH, bit 1 picks bH.
  always_comb begin
    issue      = (state_q == S_MUL) && (cnt_q < 3'd4);
    issue_step = cnt_q[1:0];
    mul_x      = issue_step[0] ? a_q[31:16] : a_q[15:0];
    mul_y      = issue_step[1] ? b_q[31:16] : b_q[15:0];
    mul_p      = 32'(mul_x) * 32'(mul_y);
  end

  generate
    if (MUL_LAT == 0) begin : g_nolat
      // Product feeds the accumulator in the cycle it is issued.
      always_comb begin
        em_v    = issue;
        em_step = issue_step;
        em_pp   = mul_p;
      end
    end else begin : g_lat
      logic        pv_q [MUL_LAT];
      logic [1:0]  ps_q [MUL_LAT];
      logic [31:0] pp_q [MUL_LAT];

      // Valid bits of the product pipeline; cleared on reset so an aborted product never lands.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT; i++) pv_q[i] <= 1'b0;
        end else begin
          pv_q[0] <= issue;
          for (int i = 1; i < MUL_LAT; i++) pv_q[i] <= pv_q[i-1];
        end
      end

      // Data side of the product pipeline, qualified by the valid bits above.
      always_ff @(posedge clk) begin
        ps_q[0] <= issue_step;
        pp_q[0] <= mul_p;
        for (int i = 1; i < MUL_LAT; i++) begin
          ps_q[i] <= ps_q[i-1];
          pp_q[i] <= pp_q[i-1];
        end
      end

      // Pipeline tail presented to the accumulator.
      always_comb begin
        em_v    = pv_q[MUL_LAT-1];
        em_step = ps_q[MUL_LAT-1];
        em_pp   = pp_q[MUL_LAT-1];
      end
    end
  endgenerate

  // Align the emerging partial product: step 0 by 0, steps 1/2 by 16, step 3 by 32.
  always_comb begin
    case (em_step)
      2'd0:    addend = {32'b0, em_pp};
      2'd3:    addend = {em_pp, 32'b0};
      default: addend = {16'b0, em_pp, 16'b0};
    endcase
  end

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = em_v ? (acc_q + addend) : acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 64'b0;
          cnt_d   = 3'd0;
          state_d = S_MUL;
`ifdef MUL_SEQ_EARLY_ZERO_EN
          if ((a == 32'b0) || (b == 32'b0)) state_d = S_DONE;
`endif
        end
      end
      S_MUL: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      a_q     <= 32'b0;
      b_q     <= 32'b0;
      acc_q   <= 64'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    prod      = acc_q;
  end

endmodule
